ecc_op_sequencer: RTL and testbench

Sequencer for the ECC datapath. It accepts an operation request from the register block and latches the 2-bit operation code. It then steps the datapath through its encode, noise-injection and decode stages with per-stage enables, and drives the registered FC_or_Dec/En_or_Dec mux selects. Completion is reported through a done/ack handshake. It sits between the APB register file and the encoder/channel/decoder pipeline.

---
 rtl/ecc_op_sequencer_pkg.sv | 26 ++
 rtl/ecc_op_sequencer_if.sv | 29 ++
 rtl/ecc_op_sequencer_stage_timer.sv | 26 ++
 rtl/ecc_op_sequencer.sv | 84 ++++++++
 tb/tb_ecc_op_sequencer.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/ecc_op_sequencer_pkg.sv
// Shared types and constants for the ECC operation sequencer.
//   seq_state_t : FSM state encoding
//   OP_*        : operation codes carried on ctrl/op_code
//   sel_for()   : maps an op code to the {FC_or_Dec, En_or_Dec} output selects
package ecc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENCODE,
    NOISE,
    DECODE,
    DONE
  } seq_state_t;

  localparam logic [1:0] OP_ENC = 2'd0;
  localparam logic [1:0] OP_DEC = 2'd1;
  localparam logic [1:0] OP_FC  = 2'd2;

  // Returns {FC_or_Dec, En_or_Dec}; codes 2 and 3 both mean full channel.
  function automatic logic [1:0] sel_for(input logic [1:0] op);
    if (op >= OP_FC)       return 2'b01;
    else if (op == OP_DEC) return 2'b11;
    else                   return 2'b00;
  endfunction

endpackage

// File: rtl/ecc_op_sequencer_if.sv
// Request/status bundle between the register block and the ECC sequencer.
//   master : register-block side (drives start, ctrl, done_ack)
//   slave  : sequencer side (drives status, selects and stage enables)
interface ecc_op_sequencer_if;
  logic       start;
  logic [1:0] ctrl;
  logic       done_ack;
  logic       busy;
  logic [1:0] op_code;
  logic       FC_or_Dec;
  logic       En_or_Dec;
  logic       enc_en;
  logic       noise_en;
  logic       dec_en;
  logic       done;
  logic       start_drop;

  modport master (
    output start, ctrl, done_ack,
    input  busy, op_code, FC_or_Dec, En_or_Dec, enc_en, noise_en, dec_en,
           done, start_drop
  );

  modport slave (
    input  start, ctrl, done_ack,
    output busy, op_code, FC_or_Dec, En_or_Dec, enc_en, noise_en, dec_en,
           done, start_drop
  );
endinterface

// File: rtl/ecc_op_sequencer_stage_timer.sv
// Stage duration down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over counting)
//   load_val   : stage length minus one
//   zero       : counter reads 0 (stage may exit); counting stops at 0
module seq_stage_timer #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - WIDTH'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ecc_op_sequencer.sv
// ECC datapath sequencer: accepts an op request, steps encode / noise /
// decode stages with one-hot enables and reports completion via done/ack.
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   bus (slave)   : start/ctrl/done_ack in; busy, op_code, selects,
//                   stage enables, done, start_drop out (all registered)
module ecc_op_sequencer
  import ecc_seq_pkg::*;
#(
  parameter int unsigned ENC_CYCLES = 1,
  parameter int unsigned DEC_CYCLES = 2
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  ecc_op_sequencer_if.slave  bus
);

  localparam int unsigned MAX_CYC = (ENC_CYCLES > DEC_CYCLES) ? ENC_CYCLES : DEC_CYCLES;
  localparam int unsigned TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] ENC_LOAD = TW'(ENC_CYCLES - 1);
  localparam logic [TW-1:0] DEC_LOAD = TW'(DEC_CYCLES - 1);

  seq_state_t    state, state_nxt;
  logic          accept;
  logic          t_load, t_zero;
  logic [TW-1:0] t_load_val;

  always_comb begin
    accept    = bus.start && (state == IDLE || (state == DONE && bus.done_ack));
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (bus.ctrl == OP_DEC) ? DECODE : ENCODE;
      ENCODE:  if (t_zero) state_nxt = (bus.op_code == OP_ENC) ? DONE : NOISE;
      NOISE:   state_nxt = DECODE;
      DECODE:  if (t_zero) state_nxt = DONE;
      DONE: begin
        if (accept)            state_nxt = (bus.ctrl == OP_DEC) ? DECODE : ENCODE;
        else if (bus.done_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A timed stage is (re)entered only from a different state, so the
    // timer load is simply "next state is timed and differs from current".
    t_load     = (state_nxt != state) && (state_nxt == ENCODE || state_nxt == DECODE);
    t_load_val = (state_nxt == ENCODE) ? ENC_LOAD : DEC_LOAD;
  end

  seq_stage_timer #(.WIDTH(TW)) u_timer (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .load     (t_load),
    .load_val (t_load_val),
    .zero     (t_zero)
  );

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they describe.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state          <= IDLE;
      bus.op_code    <= '0;
      bus.FC_or_Dec  <= 1'b0;
      bus.En_or_Dec  <= 1'b0;
      bus.enc_en     <= 1'b0;
      bus.noise_en   <= 1'b0;
      bus.dec_en     <= 1'b0;
      bus.done       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.start_drop <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.enc_en     <= (state_nxt == ENCODE);
      bus.noise_en   <= (state_nxt == NOISE);
      bus.dec_en     <= (state_nxt == DECODE);
      bus.done       <= (state_nxt == DONE);
      bus.busy       <= (state_nxt != IDLE);
      bus.start_drop <= bus.start && !accept;
      if (accept) begin
        bus.op_code                    <= bus.ctrl;
        {bus.FC_or_Dec, bus.En_or_Dec} <= sel_for(bus.ctrl);
      end
    end
  end

endmodule

// File: tb/tb_ecc_op_sequencer.sv
module tb_ecc_op_sequencer;

  logic clk;
  logic rst_n;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ecc_op_sequencer_if bus();

  ecc_op_sequencer #(.ENC_CYCLES(1), .DEC_CYCLES(2)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [9:0] v;
    string      tag;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] comp_q[$];
  logic       done_prev = 1'b0;

  // {busy, op_code, FC_or_Dec, En_or_Dec, enc_en, noise_en, dec_en, done, start_drop}
  function automatic logic [9:0] outv();
    return {bus.busy, bus.op_code, bus.FC_or_Dec, bus.En_or_Dec,
            bus.enc_en, bus.noise_en, bus.dec_en, bus.done, bus.start_drop};
  endfunction

  function automatic logic [9:0] mk(input logic b, input logic [1:0] op,
                                    input logic fc, input logic en,
                                    input logic e, input logic n, input logic d,
                                    input logic dn, input logic sd);
    return {b, op, fc, en, e, n, d, dn, sd};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Drive inputs for the current cycle; expected outputs belong to the next cycle.
  task automatic step(input logic s, input logic [1:0] c, input logic a,
                      input logic [9:0] e, input string tag);
    bus.start    = s;
    bus.ctrl     = c;
    bus.done_ack = a;
    exp_q.push_back('{cyc + 1, e, tag});
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.done_ack = 1'b0;
  endtask

  // Monitor: per-cycle scoreboard plus completion transactions on done rising.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) check({e.tag, "_missed"}, 32'(cyc), 32'(e.cyc));
      else             check(e.tag, 32'(outv()), 32'(e.v));
    end
    check("exclusive", 32'($countones({bus.enc_en, bus.noise_en, bus.dec_en, bus.done}) <= 1), 32'd1);
    if (bus.done && !done_prev) begin
      if (comp_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
      else check("completion", 32'({bus.op_code, bus.FC_or_Dec, bus.En_or_Dec}), 32'(comp_q.pop_front()));
    end
    done_prev = bus.done;
  end

  task automatic encode_seq(input string p);
    step(1, 2'd0, 0, mk(1, 2'd0, 0, 0, 1, 0, 0, 0, 0), {p, "_enc"});
    comp_q.push_back(4'b0000);
    step(0, 2'd0, 0, mk(1, 2'd0, 0, 0, 0, 0, 0, 1, 0), {p, "_done"});
    step(0, 2'd0, 0, mk(1, 2'd0, 0, 0, 0, 0, 0, 1, 0), {p, "_done_hold"});
    step(0, 2'd0, 1, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0), {p, "_idle"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.ctrl = 2'd0; bus.done_ack = 1'b0;
    #3;
    check("reset_values", 32'(outv()), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    encode_seq("encode");

    // decode; ack during DECODE and in IDLE must be ignored
    step(1, 2'd1, 0, mk(1, 2'd1, 1, 1, 0, 0, 1, 0, 0), "dec_c1");
    comp_q.push_back(4'b0111);
    step(0, 2'd0, 1, mk(1, 2'd1, 1, 1, 0, 0, 1, 0, 0), "dec_c2_ack_ignored");
    step(0, 2'd0, 0, mk(1, 2'd1, 1, 1, 0, 0, 0, 1, 0), "dec_done");
    step(0, 2'd0, 1, mk(0, 2'd1, 1, 1, 0, 0, 0, 0, 0), "dec_idle_sel_kept");
    step(0, 2'd0, 1, mk(0, 2'd1, 1, 1, 0, 0, 0, 0, 0), "idle_ack_ignored");

    // full channel, rejected starts in DECODE and DONE, then back-to-back
    step(1, 2'd3, 0, mk(1, 2'd3, 0, 1, 1, 0, 0, 0, 0), "fc_enc");
    comp_q.push_back(4'b1101);
    step(0, 2'd0, 0, mk(1, 2'd3, 0, 1, 0, 1, 0, 0, 0), "fc_noise");
    step(0, 2'd0, 0, mk(1, 2'd3, 0, 1, 0, 0, 1, 0, 0), "fc_dec1");
    step(1, 2'd0, 0, mk(1, 2'd3, 0, 1, 0, 0, 1, 0, 1), "fc_dec2_drop");
    step(0, 2'd0, 0, mk(1, 2'd3, 0, 1, 0, 0, 0, 1, 0), "fc_done");
    step(1, 2'd1, 0, mk(1, 2'd3, 0, 1, 0, 0, 0, 1, 1), "done_start_drop");
    step(1, 2'd1, 1, mk(1, 2'd1, 1, 1, 0, 0, 1, 0, 0), "b2b_dec1");
    comp_q.push_back(4'b0111);
    step(0, 2'd0, 0, mk(1, 2'd1, 1, 1, 0, 0, 1, 0, 0), "b2b_dec2");
    step(0, 2'd0, 0, mk(1, 2'd1, 1, 1, 0, 0, 0, 1, 0), "b2b_done");
    step(0, 2'd0, 1, mk(0, 2'd1, 1, 1, 0, 0, 0, 0, 0), "b2b_idle");

    // reset asserted during NOISE
    step(1, 2'd2, 0, mk(1, 2'd2, 0, 1, 1, 0, 0, 0, 0), "rst_enc");
    comp_q.push_back(4'b1001);
    step(0, 2'd0, 0, mk(1, 2'd2, 0, 1, 0, 1, 0, 0, 0), "rst_noise");
    @(negedge clk); #1 rst_n = 1'b0;
    #1;
    check("async_reset", 32'(outv()), 32'd0);
    comp_q.delete();
    step(1, 2'd1, 0, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "reset_hold1");
    step(0, 2'd0, 0, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "reset_hold2");
    @(negedge clk); #1 rst_n = 1'b1;

    encode_seq("post_rst");

    step(0, 2'd0, 0, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0), "tail");
    @(negedge clk); #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("comp_drained", 32'(comp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
